// File: rtl/handshake_eager_fork_pkg.sv
// rtl/handshake_eager_fork_pkg.sv - shared defaults and packed-bus slicing helper for the eager fork
package handshake_eager_fork_pkg;

   // Default geometry: two consumers of a 32-bit token.
   localparam int DEFAULT_SIZE      = 2;
   localparam int DEFAULT_DATA_TYPE = 32;

   // Low bit of branch idx inside a packed bus of width-bit fields.
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/handshake_eager_fork_sent_reg.sv
// rtl/handshake_eager_fork_sent_reg.sv - per-branch sent flag of the eager fork
module fork_sent_reg (
   input  logic clk,
   input  logic rst,
   input  logic v_in,
   input  logic ready,
   input  logic consumed,
   output logic valid,
   output logic done
);

   logic sent;
   logic fire;

   // Branch offers the token until it has taken it once.
   assign valid = v_in & ~sent;
   assign fire  = valid & ready;
   // Branch no longer blocks the token once delivered or delivering now.
   assign done  = sent | ready;

   // Consumption clears the flag so the next token starts clean; otherwise remember a fire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sent <= 1'b0;
      end else if (consumed) begin
         sent <= 1'b0;
      end else if (fire) begin
         sent <= 1'b1;
      end
   end

endmodule

// File: rtl/handshake_eager_fork.sv
// rtl/handshake_eager_fork.sv - eager fork replicating one token to SIZE consumers; HANDSHAKE_EAGER_FORK_INBUF_EN adds an input slot
module handshake_eager_fork
   import handshake_eager_fork_pkg::*;
#(
   parameter int SIZE      = DEFAULT_SIZE,
   parameter int DATA_TYPE = DEFAULT_DATA_TYPE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_TYPE-1:0]      ins,
   input  logic                      ins_valid,
   output logic                      ins_ready,
   output logic [SIZE*DATA_TYPE-1:0] outs,
   output logic [SIZE-1:0]           outs_valid,
   input  logic [SIZE-1:0]           outs_ready
);

   logic                 v_in;
   logic [DATA_TYPE-1:0] d_in;
   logic [SIZE-1:0]      done;
   logic                 consumed;

   // Token leaves only when every branch has it or is taking it this cycle.
   assign consumed = v_in & (&done);

`ifdef HANDSHAKE_EAGER_FORK_INBUF_EN
   logic                 vbuf;
   logic [DATA_TYPE-1:0] dbuf;

   assign v_in      = vbuf;
   assign d_in      = dbuf;
   // Slot can refill in the same cycle it drains, keeping one token per cycle.
   assign ins_ready = ~vbuf | consumed;

   // Input slot: load on accept, empty once the held token is consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vbuf <= 1'b0;
         dbuf <= '0;
      end else if (ins_valid & ins_ready) begin
         vbuf <= 1'b1;
         dbuf <= ins;
      end else if (consumed) begin
         vbuf <= 1'b0;
      end
   end
`else
   assign v_in      = ins_valid;
   assign d_in      = ins;
   assign ins_ready = &done;
`endif

   // One sent flag per consumer plus unmasked data replication.
   for (genvar gi = 0; gi < SIZE; gi++) begin : g_branch
      fork_sent_reg u_sent (
         .clk      (clk),
         .rst      (rst),
         .v_in     (v_in),
         .ready    (outs_ready[gi]),
         .consumed (consumed),
         .valid    (outs_valid[gi]),
         .done     (done[gi])
      );
      assign outs[slice_lo(gi, DATA_TYPE) +: DATA_TYPE] = d_in;
   end

endmodule

// File: tb/tb_handshake_eager_fork.sv
// tb/tb_handshake_eager_fork.sv - scoreboard bench for the two-branch eager fork
module tb_handshake_eager_fork;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] ins = '0;
   logic        ins_valid = 1'b0;
   logic        ins_ready;
   logic [63:0] outs;
   logic [1:0]  outs_valid;
   logic [1:0]  outs_ready = 2'b00;

   int errors = 0;
   int checks = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] exp_d;
   logic        accepted;
   bit          done_sim = 1'b0;

   handshake_eager_fork #(.SIZE(2), .DATA_TYPE(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: each branch fire pops that branch's expected token.
   initial begin
      forever begin
         @(negedge clk);
         if (!done_sim && rst) begin
            if (outs_valid[0] && outs_ready[0]) begin
               if (q0.size() == 0) chk("b0_unexpected", {32'h0, outs[31:0]}, 64'hdead);
               else begin
                  exp_d = q0.pop_front();
                  chk("b0_data", {32'h0, outs[31:0]}, {32'h0, exp_d});
               end
            end
            if (outs_valid[1] && outs_ready[1]) begin
               if (q1.size() == 0) chk("b1_unexpected", {32'h0, outs[63:32]}, 64'hdead);
               else begin
                  exp_d = q1.pop_front();
                  chk("b1_data", {32'h0, outs[63:32]}, {32'h0, exp_d});
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] d);
      ins       = d;
      ins_valid = 1'b1;
      q0.push_back(d);
      q1.push_back(d);
   endtask

   initial begin
      // Reset with a token offered: nothing sent, so both branches show valid.
      rst        = 1'b0;
      ins_valid  = 1'b1;
      ins        = 32'h5555;
      outs_ready = 2'b00;
      #12;
      chk("reset_valid", {62'h0, outs_valid}, 64'h3);
      chk("reset_ready", {63'h0, ins_ready}, 64'h0);
      ins_valid = 1'b0;
      step();
      rst = 1'b1;
      step();

      // Broadcast: both ready, consumed in the same cycle.
      present(32'h0000_00A5);
      outs_ready = 2'b11;
      @(negedge clk);
      chk("bcast_valid", {62'h0, outs_valid}, 64'h3);
      chk("bcast_ready", {63'h0, ins_ready}, 64'h1);
      chk("bcast_outs", outs, {32'hA5, 32'hA5});
      step();

      // Skew: branch0 first, branch1 a cycle later.
      present(32'h0000_0B0B);
      outs_ready = 2'b01;
      @(negedge clk);
      chk("skew0_valid", {62'h0, outs_valid}, 64'h3);
      chk("skew0_ready", {63'h0, ins_ready}, 64'h0);
      step();
      outs_ready = 2'b10;
      @(negedge clk);
      chk("skew1_valid", {62'h0, outs_valid}, 64'h2);
      chk("skew1_ready", {63'h0, ins_ready}, 64'h1);
      step();

      // Stall: no consumer ready for five cycles.
      present(32'h0000_1234);
      outs_ready = 2'b00;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_valid", {62'h0, outs_valid}, 64'h3);
         chk("stall_ready", {63'h0, ins_ready}, 64'h0);
         chk("stall_outs", outs, {32'h1234, 32'h1234});
         step();
      end
      outs_ready = 2'b11;
      step();

      // Stream of 8 tokens with random consumer readiness.
      void'($urandom(1));
      for (int t = 0; t < 8; t++) begin
         present(32'(t));
         accepted = 1'b0;
         for (int c = 0; c < 60 && !accepted; c++) begin
            outs_ready = 2'($urandom_range(0, 3));
            @(negedge clk);
            accepted = ins_ready;
            step();
         end
         if (!accepted) chk("stream_timeout", 64'(t), 64'hffff);
      end
      ins_valid  = 1'b0;
      outs_ready = 2'b00;
      step();

      // Mid-token reset: branch0 already delivered, reset clears its flag.
      present(32'h0000_0C0C);
      outs_ready = 2'b01;
      step();
      outs_ready = 2'b00;
      @(negedge clk);
      chk("mid_valid_before", {62'h0, outs_valid}, 64'h2);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_valid_reset", {62'h0, outs_valid}, 64'h3);
      step();
      rst = 1'b1;
      q0.push_back(32'h0000_0C0C);
      outs_ready = 2'b11;
      @(negedge clk);
      chk("mid_ready_after", {63'h0, ins_ready}, 64'h1);
      step();
      ins_valid  = 1'b0;
      outs_ready = 2'b00;
      step();

      chk("q0_drained", 64'(q0.size()), 64'h0);
      chk("q1_drained", 64'(q1.size()), 64'h0);
      done_sim = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
